// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and default geometry for the single-clock FIFO.
package sync_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    // Ceiling log2; returns 1 for inputs of 0 or 1 so address buses stay legal.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ram_1r1w.sv
// WIDTH x DEPTH storage: synchronous write port, read port registered (REG_RD=1)
// or combinational (REG_RD=0).
module fifo_ram_1r1w #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int REG_RD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (REG_RD != 0) begin : g_reg_rd
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data <= '0;
                end else if (rd_en) begin
                    rd_data <= mem[rd_addr];
                end
            end
        end else begin : g_comb_rd
            assign rd_data = mem[rd_addr];
        end
    endgenerate

    // rd_en/rst_n are only consumed by the registered read port.
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = rd_en ^ rst_n;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with fill count, threshold flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       din,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [clog2(DEPTH):0]  count,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   err_clr
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef SYNC_FIFO_FWFT_EN
    localparam int REG_RD = 0;
`else
    localparam int REG_RD = 1;
`endif

    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             wa;
    logic             ra;
    logic [WIDTH-1:0] ram_rd;

    assign wa = wr_en & ~full;
    assign ra = rd_en & ~empty;

    always_comb begin
        count_nxt = count;
        case ({wa, ra})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wa) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (ra) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
        end
    end

    // Flags come from count_nxt so they line up with the registered count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            count        <= count_nxt;
            full         <= (count_nxt == CW'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CW'(AF_LEVEL));
            almost_empty <= (count_nxt <= CW'(AE_LEVEL));
        end
    end

    // A fresh error outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    fifo_ram_1r1w #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .REG_RD (REG_RD)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wa),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (din),
        .rd_en   (ra),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (ram_rd)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign dout = empty ? '0 : ram_rd;
`else
    assign dout = ram_rd;
`endif

    // Wrap bits are kept for pointer bookkeeping; occupancy is tracked by count.
    logic unused_ptr_msb;
    assign unused_ptr_msb = wr_ptr[AW] ^ rd_ptr[AW];

endmodule
